// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: read/write codes, byte-enable
// constant, FSM state encoding and owner codes.
package sram_arbiter_pkg;

  localparam logic       RW_READ  = 1'b1;
  localparam logic       RW_WRITE = 1'b0;
  localparam logic [3:0] BE_ALL_N = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Owner code doubles as the bit index into the request/grant vectors.
  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

endpackage

// File: rtl/sram_arbiter_arb_rr2.sv
// arb_rr2: 2-input round-robin picker.
//   clk_i, rst_i : clock, async active-high reset
//   req[1:0]     : requests (bit 0 = IF, bit 1 = MEM)
//   advance      : grant was taken this cycle; record it as last_grant
//   grant[1:0]   : one-hot grant (combinational from req and last_grant)
module arb_rr2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // 0 = IF was granted last, 1 = MEM was granted last.
  logic last_mem;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_mem ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  last_mem <= 1'b0;
    else if (advance && |grant) last_mem <= grant[1];
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one sram_ctl between instruction fetch (IF, read-only)
// and the MEM stage (read/write). Round-robin grant, IDLE -> ISSUE -> WAIT
// sequencing of the sram_ctl start/ready/finish handshake, fetch stall.
//
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   if_req_i/if_addr_i                IF read request
//   if_gnt_o/if_rvalid_o/if_rdata_o   IF accept pulse, data-valid pulse, data
//   mem_req_i/rw/addr/wdata/be_n_i    MEM request
//   mem_gnt_o/rvalid/wdone/rdata_o    MEM accept, read-valid, write-done, data
//   ctl_*_o                           registered command to sram_ctl
//   ctl_data_i/r_ready/w_finish/busy  sram_ctl responses
//   stall_o                           fetch stall to pc_reg
//   timeout_o                         abort pulse (0 unless timeout enabled)
//
// Optional feature: define SRAM_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles without completion.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              mem_req_i,
  input  logic              mem_rw_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [3:0]        mem_be_n_i,
  output logic              mem_gnt_o,
  output logic              mem_rvalid_o,
  output logic              mem_wdone_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              ctl_start_o,
  output logic              ctl_rw_o,
  output logic [ADDR_W-1:0] ctl_addr_o,
  output logic [DATA_W-1:0] ctl_data_o,
  output logic [3:0]        ctl_be_n_o,
  input  logic [DATA_W-1:0] ctl_data_i,
  input  logic              ctl_r_ready_i,
  input  logic              ctl_w_finish_i,
  input  logic              ctl_busy_i,
  output logic              stall_o,
  output logic              timeout_o
);

  typedef struct packed {
    logic              rw;
    logic [3:0]        be_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ctl_req_t;

  localparam ctl_req_t CTL_RST = '{rw: RW_READ, be_n: 4'hF,
                                   addr: {ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};

  state_e            state, state_nxt;
  owner_e            owner;
  ctl_req_t          ctl_q, if_fields, mem_fields;
  logic [1:0]        grant;
  logic              take, fin, complete, expire, is_read;
  logic [DATA_W-1:0] rd_word;

  arb_rr2 u_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     ({mem_req_i, if_req_i}),
    .advance (take),
    .grant   (grant)
  );

  assign if_fields  = '{rw: RW_READ, be_n: BE_ALL_N, addr: if_addr_i,
                        data: {DATA_W{1'b0}}};
  assign mem_fields = '{rw: mem_rw_i, be_n: mem_be_n_i, addr: mem_addr_i,
                        data: mem_wdata_i};

  // Only the flag matching the latched direction counts as completion.
  assign is_read  = (ctl_q.rw == RW_READ);
  assign complete = is_read ? ctl_r_ready_i : ctl_w_finish_i;
  // An aborted read returns zero.
  assign rd_word  = expire ? {DATA_W{1'b0}} : ctl_data_i;

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Counter is zero in the first WAIT cycle; expiry fires on the edge that
  // closes the TIMEOUT-th WAIT cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      wait_cnt  <= (state == ST_WAIT) ? wait_cnt + CNT_W'(1) : '0;
      timeout_o <= expire;
    end
  end

  assign expire = (state == ST_WAIT) & ~complete &
                  (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expire         = 1'b0;
  assign timeout_o      = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    fin       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|grant) begin
          take      = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!ctl_busy_i) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (complete || expire) begin
          fin       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      owner        <= OWN_IF;
      ctl_q        <= CTL_RST;
      if_gnt_o     <= 1'b0;
      mem_gnt_o    <= 1'b0;
      if_rvalid_o  <= 1'b0;
      mem_rvalid_o <= 1'b0;
      mem_wdone_o  <= 1'b0;
      if_rdata_o   <= '0;
      mem_rdata_o  <= '0;
    end else begin
      state        <= state_nxt;
      if_gnt_o     <= take & grant[0];
      mem_gnt_o    <= take & grant[1];
      if_rvalid_o  <= fin & is_read & (owner == OWN_IF);
      mem_rvalid_o <= fin & is_read & (owner == OWN_MEM);
      mem_wdone_o  <= fin & ~is_read;
      if (take) begin
        owner <= grant[1] ? OWN_MEM : OWN_IF;
        ctl_q <= grant[1] ? mem_fields : if_fields;
      end
      if (fin && is_read) begin
        if (owner == OWN_IF) if_rdata_o  <= rd_word;
        else                 mem_rdata_o <= rd_word;
      end
    end
  end

  assign ctl_start_o = (state == ST_ISSUE);
  assign ctl_rw_o    = ctl_q.rw;
  assign ctl_be_n_o  = ctl_q.be_n;
  assign ctl_addr_o  = ctl_q.addr;
  assign ctl_data_o  = ctl_q.data;
  assign stall_o     = if_req_i & ~if_rvalid_o;

endmodule
